// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the streaming instruction loader.
package prog_loader_pkg;

    localparam int unsigned AW_DEF = 11;
    localparam int unsigned IW_DEF = 9;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SUM_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_CNT_HI  = 3'd2,
        ST_INST_LO = 3'd3,
        ST_INST_HI = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // States that consume a byte from the stream.
    function automatic logic state_takes_byte(input state_e s);
        return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_INST_LO) ||
               (s == ST_INST_HI) || (s == ST_CHK);
    endfunction

    // States belonging to an active load session.
    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/prog_loader_inst_ram.sv
// Instruction RAM: synchronous write, combinational read, no reset.
module inst_ram #(
    parameter int unsigned AW = 11,
    parameter int unsigned IW = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [IW-1:0] mem_q [DEPTH];

    // Write port; a read of the same address this cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader that packs instructions into the fetch RAM and checks a checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned IW = IW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteReady,
    input  logic [AW-1:0] InstAddress,
    output logic [IW-1:0] InstOut,
    output logic          Busy,
    output logic          Done,
    output logic          Error
);

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept_c;
    logic                we_c;
    logic [IW-1:0]       wdata_c;
    logic [AW-1:0]       cnt_hi_c;

    assign accept_c = ByteValid & ready_q;
    assign wdata_c  = {ByteIn[IW-9:0], lo_q};
    assign cnt_hi_c = {ByteIn[AW-9:0], cnt_q[7:0]};

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            lo_q    <= '0;
            sum_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            lo_q    <= lo_d;
            sum_q   <= sum_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath update and RAM write strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        sum_d   = sum_q;
        done_d  = done_q;
        err_d   = err_q;
        we_c    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_CNT_LO;
                    ptr_d   = '0;
                    sum_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_CNT_LO: begin
                if (accept_c) begin
                    cnt_d   = {cnt_q[AW-1:8], ByteIn};
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept_c) begin
                    cnt_d = cnt_hi_c;
                    if (cnt_hi_c == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_INST_LO;
                    end
                end
            end
            ST_INST_LO: begin
                if (accept_c) begin
                    lo_d    = ByteIn;
                    sum_d   = sum_q + SUM_W'(ByteIn);
                    state_d = ST_INST_HI;
                end
            end
            ST_INST_HI: begin
                if (accept_c) begin
                    we_c  = 1'b1;
                    sum_d = sum_q + SUM_W'(ByteIn);
                    ptr_d = ptr_q + AW'(1);
                    // Count is at least 1 here, so count-1 never underflows.
                    if (ptr_q == (cnt_q - AW'(1))) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_INST_LO;
                    end
                end
            end
            ST_CHK: begin
                if (accept_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = (ByteIn != sum_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags registered alongside the state they decode.
    always_comb begin
        ready_d = state_takes_byte(state_d);
        busy_d  = state_is_busy(state_d);
    end

    inst_ram #(
        .AW (AW),
        .IW (IW)
    ) u_ram (
        .clk     (Clk),
        .we_i    (we_c),
        .waddr_i (ptr_q),
        .wdata_i (wdata_c),
        .raddr_i (InstAddress),
        .rdata_o (InstOut)
    );

    assign ByteReady = ready_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = err_q;

endmodule
